// File: rtl/mux81_rr_arb_pkg.sv
// Shared definitions for the 8:1 mux round-robin arbiter: FSM encodings and sizes.
package mux81_rr_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/mux81_rr_arb_rr_pick8.sv
// Combinational round-robin picker.
// The request vector is rotated so that ptr lands on bit 0. The lowest set bit
// is then found, and ptr is added back to give the winner's absolute index.
module rr_pick8
  import mux81_rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             valid,
  output logic [SEL_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [SEL_W-1:0]   off;

  // rotate right by ptr, priority-encode lowest set bit, undo the rotation
  always_comb begin
    dbl = {req, req};
    rot = dbl[ptr +: N_REQ];
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    idx   = off + ptr;
    valid = |req;
  end

endmodule

// File: rtl/mux81_rr_arb.sv
// Round-robin arbiter in front of an 8:1 mux. One tenure runs at a time, and
// each tenure is limited by HOLD_MAX. A single dead GAP cycle follows every
// release, so a request that rises on the release edge is only seen when the
// GAP ends.
module mux81_rr_arb
  import mux81_rr_arb_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [N_REQ-1:0] Req,
  output logic [N_REQ-1:0] Grant,
  output logic [SEL_W-1:0] Sel,
  output logic             CSn,
  output logic             Busy
);

  state_t           state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n;
  logic [SEL_W-1:0] sel_n;
  logic [N_REQ-1:0] grant_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             pick_vld;
  logic [SEL_W-1:0] pick_idx;

  rr_pick8 u_pick (
    .req   (Req),
    .ptr   (ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  // state and registered outputs; the async clear forces CSn high at once
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= ST_IDLE;
      ptr   <= '0;
      Sel   <= '0;
      Grant <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      Sel   <= sel_n;
      Grant <= grant_n;
      cnt   <= cnt_n;
    end
  end

  // next-state logic: arbitrate from IDLE or GAP, release on a dropped request or on timeout
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = Sel;
    grant_n = Grant;
    cnt_n   = cnt;
    unique case (state)
      ST_GRANT: begin
        if (!Req[Sel] || cnt == CNT_W'(HOLD_MAX)) begin
          // The pointer moves past the grantee, so a requester that timed out
          // and still requests now has the lowest priority.
          grant_n = '0;
          ptr_n   = Sel + SEL_W'(1);
          state_n = ST_GAP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        if (pick_vld) begin
          sel_n   = pick_idx;
          grant_n = N_REQ'(1) << pick_idx;
          cnt_n   = CNT_W'(1);
          state_n = ST_GRANT;
        end else begin
          grant_n = '0;
          state_n = ST_IDLE;
        end
      end
    endcase
  end

  assign CSn  = ~(|Grant);
  assign Busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mux81_rr_arb.sv
// Directed bench for mux81_rr_arb with HOLD_MAX=16.
module tb_mux81_rr_arb;

  logic       Clk;
  logic       Rst_n;
  logic [7:0] Req;
  logic [7:0] Grant;
  logic [2:0] Sel;
  logic       CSn;
  logic       Busy;

  int checks;
  int errors;

  mux81_rr_arb #(.HOLD_MAX(16), .CNT_W(8)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Req   (Req),
    .Grant (Grant),
    .Sel   (Sel),
    .CSn   (CSn),
    .Busy  (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset;
    Req   = 8'h00;
    Rst_n = 1'b0;
    #12;
    Rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    Req   = 8'h00;
    Rst_n = 1'b0;
    #7;
    checks++;
    if (Grant !== 8'h00 || CSn !== 1'b1 || Sel !== 3'd0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: Grant=%h CSn=%b Sel=%0d Busy=%b, want 00 1 0 0", Grant, CSn, Sel, Busy);
    end
    Rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    do_reset();
    Req = 8'h08;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (Grant !== 8'h08 || Sel !== 3'd3 || CSn !== 1'b0 || Busy !== 1'b1) begin
        errors++;
        $display("FAIL single_grant c%0d: Grant=%h Sel=%0d CSn=%b Busy=%b, want 08 3 0 1", c, Grant, Sel, CSn, Busy);
      end
    end
    Req = 8'h00;
    tick();
    checks++;
    if (Grant !== 8'h00 || CSn !== 1'b1 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL single_gap: Grant=%h CSn=%b Busy=%b, want 00 1 1", Grant, CSn, Busy);
    end
    tick();
    checks++;
    if (Busy !== 1'b0 || Sel !== 3'd3 || CSn !== 1'b1) begin
      errors++;
      $display("FAIL single_idle: Busy=%b Sel=%0d CSn=%b, want 0 3 1", Busy, Sel, CSn);
    end
    // ptr is now 4, so with requests on bits 0 and 3 the search wraps to bit 0
    Req = 8'h09;
    tick();
    checks++;
    if (Grant !== 8'h01 || Sel !== 3'd0) begin
      errors++;
      $display("FAIL single_ptr4: Grant=%h Sel=%0d, want 01 0", Grant, Sel);
    end
    Req = 8'h00;
    tick(); tick(); tick();
  endtask

  task automatic test_round_robin;
    logic [7:0] exp;
    do_reset();
    Req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      exp = 8'h01 << (g % 8);
      for (int c = 0; c < 16; c++) begin
        tick();
        checks++;
        if (Grant !== exp || CSn !== 1'b0 || Sel !== 3'(g % 8)) begin
          errors++;
          $display("FAIL rr_grant g%0d c%0d: Grant=%h Sel=%0d CSn=%b, want %h %0d 0", g, c, Grant, Sel, CSn, exp, g % 8);
        end
      end
      tick();
      checks++;
      if (Grant !== 8'h00 || CSn !== 1'b1) begin
        errors++;
        $display("FAIL rr_gap g%0d: Grant=%h CSn=%b, want 00 1", g, Grant, CSn);
      end
    end
    Req = 8'h00;
    tick();
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle: Busy=%b, want 0", Busy);
    end
  endtask

  task automatic test_wrap;
    do_reset();
    Req = 8'h40;
    tick();
    checks++;
    if (Grant !== 8'h40 || Sel !== 3'd6) begin
      errors++;
      $display("FAIL wrap_pre: Grant=%h Sel=%0d, want 40 6", Grant, Sel);
    end
    Req = 8'h00;
    tick(); tick();
    Req = 8'h81;
    for (int c = 0; c < 16; c++) begin
      tick();
      checks++;
      if (Grant !== 8'h80 || Sel !== 3'd7) begin
        errors++;
        $display("FAIL wrap_first c%0d: Grant=%h Sel=%0d, want 80 7", c, Grant, Sel);
      end
    end
    tick();
    checks++;
    if (Grant !== 8'h00 || CSn !== 1'b1) begin
      errors++;
      $display("FAIL wrap_gap: Grant=%h CSn=%b, want 00 1", Grant, CSn);
    end
    tick();
    checks++;
    if (Grant !== 8'h01 || Sel !== 3'd0) begin
      errors++;
      $display("FAIL wrap_second: Grant=%h Sel=%0d, want 01 0", Grant, Sel);
    end
    Req = 8'h00;
    tick(); tick(); tick();
  endtask

  task automatic test_timeout;
    logic [7:0] exp;
    do_reset();
    Req = 8'h20;
    for (int t = 1; t <= 40; t++) begin
      tick();
      exp = (t == 17 || t == 34) ? 8'h00 : 8'h20;
      checks++;
      if (Grant !== exp || Sel !== 3'd5 || CSn !== (exp == 8'h00)) begin
        errors++;
        $display("FAIL timeout t%0d: Grant=%h Sel=%0d CSn=%b, want %h 5 %b", t, Grant, Sel, CSn, exp, exp == 8'h00);
      end
    end
    Req = 8'h00;
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid;
    do_reset();
    Req = 8'h04;
    tick();
    checks++;
    if (Grant !== 8'h04 || Sel !== 3'd2) begin
      errors++;
      $display("FAIL rstmid_pre: Grant=%h Sel=%0d, want 04 2", Grant, Sel);
    end
    tick();
    #3;
    Rst_n = 1'b0;
    #1;
    checks++;
    if (Grant !== 8'h00 || CSn !== 1'b1 || Sel !== 3'd0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: Grant=%h CSn=%b Sel=%0d Busy=%b, want 00 1 0 0", Grant, CSn, Sel, Busy);
    end
    Req = 8'h06;
    #2;
    Rst_n = 1'b1;
    tick();
    checks++;
    if (Grant !== 8'h02 || Sel !== 3'd1 || CSn !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_regrant: Grant=%h Sel=%0d CSn=%b, want 02 1 0", Grant, Sel, CSn);
    end
    Req = 8'h00;
    tick(); tick(); tick();
  endtask

  task automatic test_same_edge;
    do_reset();
    Req = 8'h01;
    tick();
    checks++;
    if (Grant !== 8'h01 || Sel !== 3'd0) begin
      errors++;
      $display("FAIL same_first: Grant=%h Sel=%0d, want 01 0", Grant, Sel);
    end
    Req = 8'h10;
    tick();
    checks++;
    if (Grant !== 8'h00 || CSn !== 1'b1 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL same_gap: Grant=%h CSn=%b Busy=%b, want 00 1 1", Grant, CSn, Busy);
    end
    tick();
    checks++;
    if (Grant !== 8'h10 || Sel !== 3'd4 || CSn !== 1'b0) begin
      errors++;
      $display("FAIL same_next: Grant=%h Sel=%0d CSn=%b, want 10 4 0", Grant, Sel, CSn);
    end
    Req = 8'h00;
    tick(); tick(); tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Rst_n  = 1'b1;
    Req    = 8'h00;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_reset_mid();
    test_same_edge();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
